// File: rtl/cpu_bus_sequencer_pkg.sv
// Shared CPU definitions: bus sequencer states, T-cycle encodings and a
// helper that sizes the wait-state counter.
package cpu_bus_sequencer_pkg;

  // Bus sequencer state machine encoding
  typedef enum logic [1:0] {
    BusIdle,
    BusAccess,
    BusWait
  } bus_state_e;

  // T-cycle numbering shared with cpu_control
  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  // Width able to hold 0..max_wait, never narrower than one bit
  function automatic int wait_cnt_width(input int max_wait);
    int w;
    w = $clog2(max_wait + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cpu_bus_sequencer_if.sv
// Request and external-bus signal bundle for the bus sequencer.
// The master side is the CPU plus external memory (it issues requests and
// answers with ready/read data); the slave side is the sequencer itself.
interface cpu_bus_sequencer_if;

  // Request from cpu_control
  logic        mem_enable;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;

  // Response from the external bus
  logic        bus_ready;
  logic [7:0]  bus_rdata;

  // Sequencer outputs
  logic [1:0]  t_cycle;
  logic [7:0]  mem_data_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        stalled;
  logic        bus_timeout;

  modport master (
    output mem_enable, mem_write, mem_addr, mem_wdata, bus_ready, bus_rdata,
    input  t_cycle, mem_data_in, bus_addr, bus_wdata, bus_rd, bus_wr,
           stalled, bus_timeout
  );

  modport slave (
    input  mem_enable, mem_write, mem_addr, mem_wdata, bus_ready, bus_rdata,
    output t_cycle, mem_data_in, bus_addr, bus_wdata, bus_rd, bus_wr,
           stalled, bus_timeout
  );

endinterface

// File: rtl/cpu_bus_sequencer.sv
// CPU bus sequencer: paces the 4-phase T-cycle, turns the per-M-cycle
// memory request into a timed external bus transaction, captures read data,
// and stretches T2 with wait states (with optional forced completion).
// Every output is a flop, so an asynchronous reset can never glitch a strobe.
module cpu_bus_sequencer
  import cpu_bus_sequencer_pkg::*;
#(
  parameter int         MAX_WAIT      = 8,
  parameter logic [7:0] OPEN_BUS_DATA = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  cpu_bus_sequencer_if.slave bus
);

  localparam int              CNT_W      = wait_cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
  localparam bit              TIMEOUT_EN = (MAX_WAIT > 0);

  bus_state_e       state;
  logic [1:0]       t_cycle;
  logic             req_write;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       mem_data_in;
  logic [15:0]      bus_addr;
  logic [7:0]       bus_wdata;
  logic             bus_rd;
  logic             bus_wr;
  logic             stalled;
  logic             bus_timeout;

  logic [CNT_W-1:0] wait_cnt_next;
  logic             wait_expired;

  // Count of wait clocks including the current one; forced completion fires
  // when that count reaches the limit.
  assign wait_cnt_next = wait_cnt + CNT_W'(1);
  assign wait_expired  = TIMEOUT_EN && (wait_cnt_next == WAIT_LIMIT);

  // Sequencer FSM: T-cycle counter, request capture, strobes and read capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BusIdle;
      t_cycle     <= T0;
      req_write   <= 1'b0;
      wait_cnt    <= '0;
      mem_data_in <= 8'h00;
      bus_addr    <= 16'h0000;
      bus_wdata   <= 8'h00;
      bus_rd      <= 1'b0;
      bus_wr      <= 1'b0;
      stalled     <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= 1'b0;
      case (state)
        BusIdle: begin
          t_cycle <= t_cycle + 2'd1;
          // Request is sampled only on the edge that ends T0
          if (t_cycle == T0 && bus.mem_enable) begin
            state     <= BusAccess;
            req_write <= bus.mem_write;
            bus_addr  <= bus.mem_addr;
            bus_wdata <= bus.mem_wdata;
            bus_rd    <= !bus.mem_write;
          end
        end

        BusAccess: begin
          case (t_cycle)
            T1: begin
              t_cycle <= T2;
              // Write strobe is confined to T2 (and any wait states)
              bus_wr  <= req_write;
            end
            T2: begin
              if (bus.bus_ready) begin
                t_cycle <= T3;
                bus_rd  <= 1'b0;
                bus_wr  <= 1'b0;
                if (!req_write) begin
                  mem_data_in <= bus.bus_rdata;
                end
              end else begin
                state    <= BusWait;
                stalled  <= 1'b1;
                wait_cnt <= '0;
              end
            end
            default: begin
              // End of T3: back to idle for the next M-cycle's T0
              t_cycle <= T0;
              state   <= BusIdle;
            end
          endcase
        end

        BusWait: begin
          // t_cycle stays at T2 and strobes hold until the access finishes
          if (bus.bus_ready || wait_expired) begin
            state       <= BusAccess;
            t_cycle     <= T3;
            stalled     <= 1'b0;
            bus_rd      <= 1'b0;
            bus_wr      <= 1'b0;
            wait_cnt    <= '0;
            bus_timeout <= !bus.bus_ready;
            if (!req_write) begin
              mem_data_in <= bus.bus_ready ? bus.bus_rdata : OPEN_BUS_DATA;
            end
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt_next;
          end
        end

        default: begin
          state   <= BusIdle;
          t_cycle <= T0;
        end
      endcase
    end
  end

  assign bus.t_cycle     = t_cycle;
  assign bus.mem_data_in = mem_data_in;
  assign bus.bus_addr    = bus_addr;
  assign bus.bus_wdata   = bus_wdata;
  assign bus.bus_rd      = bus_rd;
  assign bus.bus_wr      = bus_wr;
  assign bus.stalled     = stalled;
  assign bus.bus_timeout = bus_timeout;

endmodule

// File: doc/cpu_bus_sequencer.md
Name: cpu_bus_sequencer

Overview:
- Generates the 4-phase T-cycle count (t_cycle 0..3) that paces cpu_control.
- Turns cpu_control's per-M-cycle memory request (enable, write, resolved 16-bit address, write data) into a timed external bus transaction.
- Captures read data into the registered mem_data_in bus, which feeds instruction dispatch and the datapath.
- Stretches the M-cycle by holding t_cycle at 2 while the external bus is not ready, with an optional timeout.

Parameters:
- MAX_WAIT, 8, maximum stall clocks per access before forced completion; 0 disables the timeout.
- OPEN_BUS_DATA, 8'hFF, value returned on a timed-out read.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- mem_enable  input  1  request a memory access this M-cycle
- mem_write  input  1  access is a write (valid with mem_enable)
- mem_addr  input  16  resolved access address
- mem_wdata  input  8  write data
- bus_ready  input  1  external bus can complete the access this clock
- bus_rdata  input  8  external read data
- t_cycle  output  2  current T-cycle, to cpu_control
- mem_data_in  output  8  registered read data
- bus_addr  output  16  external address
- bus_wdata  output  8  external write data
- bus_rd  output  1  read strobe
- bus_wr  output  1  write strobe
- stalled  output  1  high while t_cycle is frozen at 2
- bus_timeout  output  1  one-clock pulse on forced completion

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - t_cycle=0, mem_data_in=8'h00, bus_addr=16'h0000, bus_wdata=8'h00.
  - bus_rd, bus_wr, stalled, bus_timeout = 0; stall counter = 0; latched request cleared.
  - Reset mid-stall or mid-access abandons the access with no strobe glitch, because all strobes come from registers.
- T-cycle counter: increments once per clk, wrapping 3->0. It does not advance while in the WAIT state.
- Request capture: on the rising edge that ends T0, latch mem_enable, mem_write, mem_addr and mem_wdata. Input changes during T1..T3 are ignored.
- State machine (IDLE, ACCESS, WAIT), all outputs registered:
  - IDLE: covers T0, and all of T1..T3 when no request was latched. Strobes low; bus_addr and bus_wdata hold their last values.
  - ACCESS: entered at the end of T0 when a request was latched.
    - bus_addr and bus_wdata are driven T1..T3.
    - Read: bus_rd is high during T1..T2.
    - Write: bus_wr is high during T2 only.
  - Completion at the edge ending T2:
    - If bus_ready=1: a read loads bus_rdata into mem_data_in, a write completes, t_cycle goes to 3 and strobes drop.
    - If bus_ready=0: enter WAIT.
  - WAIT: t_cycle held at 2, stalled=1, strobes held, stall counter increments each clk.
    - Exit on bus_ready=1 (same completion actions as above).
    - Or exit when the counter reaches MAX_WAIT (MAX_WAIT>0): read loads OPEN_BUS_DATA, bus_timeout pulses for one clock, t_cycle goes to 3.
    - The counter clears on exit.
- mem_data_in is stable during T3 and holds until the next completed read; writes never change it.
- bus_ready is ignored when no access is active. No stall without a request.
- Latency, read: request at T0 -> data valid at T3 of the same M-cycle; 4 clocks with no wait, 4+N with N wait clocks.
- Back-to-back accesses: a new capture at the next T0 edge. bus_addr may change at T1 with no idle clock.
- Counter width: clog2(MAX_WAIT+1), minimum 1 bit.

Decomposition:
- Shared cpu package holds:
  - enum bus_state_e {BusIdle, BusAccess, BusWait};
  - T-cycle constants T0..T3 (2-bit), used by both cpu_control and this block.
- No sub-module. The stall counter is inline.

Test Plan:
- Reset then 8 free-running clocks, mem_enable=0 -> t_cycle 0,1,2,3,0,1,2,3; all strobes low; mem_data_in=00.
- Read from 16'hC000, bus_rdata=8'h3E, bus_ready=1 -> bus_rd high T1..T2, bus_addr=C000 T1..T3, mem_data_in=3E at T3, stalled never high.
- Write 8'hA5 to 16'hFF80 -> bus_wr high exactly one clock at T2, bus_wdata=A5 T1..T3, mem_data_in unchanged.
- Read with bus_ready low for 3 clocks -> t_cycle=2 for 4 clocks, stalled=1 for 3 clocks, data loaded on the ready clock, M-cycle length 7 clocks.
- Read with bus_ready stuck low, MAX_WAIT=8 -> 8 stall clocks, bus_timeout one-clock pulse, mem_data_in=FF, t_cycle resumes at 3.
- Assert reset during WAIT -> t_cycle=0 and bus_rd=0 immediately (before the next edge); after release, the counter restarts from 0.
